// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter
// Shares one single-ported, fixed-latency memory between instruction fetch (IF)
// and load/store (DM). DM wins ties unless fetch has been passed over STARVE_MAX
// times in a row. Each transaction walks IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Ready and read data are registered and appear in the IDLE cycle after RESP.
module pipe_mem_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_ready,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic [DW-1:0] dm_rdata,
   output logic          dm_ready,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          stall_if,
   output logic          stall_mem,
   output logic          busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_DM = 1'b1;

   // cnt only ever holds MEM_LAT-1 down to 1; streak holds 0..STARVE_MAX
   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [SW-1:0] streak;
   logic          owner;
   logic [AW-1:0] lat_addr;
   logic          lat_we;
   logic [DW-1:0] lat_wdata;

   logic if_elig;
   logic dm_elig;
   logic grant_dm;
   logic grant_if;

   // Arbitration: a port whose ready is pulsing is masked so a held request is
   // not granted twice; DM wins ties until fetch has been starved too long
   always_comb begin
      if_elig  = if_req & ~if_ready;
      dm_elig  = dm_req & ~dm_ready;
      grant_dm = dm_elig & (~if_elig | (streak != SW'(STARVE_MAX)));
      grant_if = if_elig & ~grant_dm;
   end

   // Transaction sequencer: latches the winner's request, strobes the memory,
   // waits out the latency and returns read data plus a one-cycle ready
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         streak    <= '0;
         owner     <= OWN_IF;
         lat_addr  <= '0;
         lat_we    <= 1'b0;
         lat_wdata <= '0;
         if_ready  <= 1'b0;
         dm_ready  <= 1'b0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
      end else begin
         if_ready <= 1'b0;
         dm_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_dm) begin
                  owner     <= OWN_DM;
                  lat_addr  <= dm_addr;
                  lat_we    <= dm_we;
                  lat_wdata <= dm_wdata;
                  state     <= ISSUE;
                  if (!if_req)
                     streak <= '0;
                  else if (streak != SW'(STARVE_MAX))
                     streak <= streak + SW'(1);
               end else if (grant_if) begin
                  owner     <= OWN_IF;
                  lat_addr  <= if_addr;
                  lat_we    <= 1'b0;
                  lat_wdata <= '0;
                  state     <= ISSUE;
                  streak    <= '0;
               end
            end
            ISSUE: begin
               cnt   <= CW'(MEM_LAT - 1);
               state <= (MEM_LAT == 1) ? RESP : WAIT;
            end
            WAIT: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1))
                  state <= RESP;
            end
            RESP: begin
               if (owner == OWN_DM) begin
                  dm_ready <= 1'b1;
                  if (!lat_we)
                     dm_rdata <= mem_rdata;
               end else begin
                  if_ready <= 1'b1;
                  if_rdata <= mem_rdata;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mem_en    = (state == ISSUE);
   assign mem_we    = mem_en & lat_we;
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;
   assign stall_if  = if_req & ~if_ready;
   assign stall_mem = dm_req & ~dm_ready;
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// tb_pipe_mem_arbiter
// Directed bench for pipe_mem_arbiter: one instance with MEM_LAT=2 and one with
// MEM_LAT=1, each backed by a small behavioural memory returning a known pattern.
module tb_pipe_mem_arbiter;

   logic clock = 1'b0;
   logic reset;

   logic        ifReq0, dmReq0, dmWe0;
   logic [31:0] ifAddr0, dmAddr0, dmWdata0;
   logic [31:0] if_rdata0, dm_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
   logic        if_ready0, dm_ready0, mem_en0, mem_we0, stall_if0, stall_mem0, busy0;
   logic [31:0] rdPipe0;

   logic        ifReq1;
   logic [31:0] ifAddr1;
   logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
   logic        if_ready1, dm_ready1, mem_en1, mem_we1, stall_if1, stall_mem1, busy1;

   int totalChecks = 0;
   int badChecks   = 0;

   always #5 clock = ~clock;

   pipe_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .STARVE_MAX(4)) u_dut (
      .clock(clock), .reset(reset),
      .if_req(ifReq0), .if_addr(ifAddr0), .if_rdata(if_rdata0), .if_ready(if_ready0),
      .dm_req(dmReq0), .dm_we(dmWe0), .dm_addr(dmAddr0), .dm_wdata(dmWdata0),
      .dm_rdata(dm_rdata0), .dm_ready(dm_ready0),
      .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
      .mem_rdata(mem_rdata0),
      .stall_if(stall_if0), .stall_mem(stall_mem0), .busy(busy0)
   );

   pipe_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
      .clock(clock), .reset(reset),
      .if_req(ifReq1), .if_addr(ifAddr1), .if_rdata(if_rdata1), .if_ready(if_ready1),
      .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
      .dm_rdata(dm_rdata1), .dm_ready(dm_ready1),
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_rdata(mem_rdata1),
      .stall_if(stall_if1), .stall_mem(stall_mem1), .busy(busy1)
   );

   // Memory contents: one fixed instruction word, otherwise address-derived data
   function automatic logic [31:0] lookup(input logic [31:0] a);
      if (a == 32'h40)
         return 32'h8C020000;
      return {a[15:0], ~a[15:0]};
   endfunction

   // Two-cycle memory for the MEM_LAT=2 instance
   always @(posedge clock) begin
      rdPipe0    <= mem_en0 ? lookup(mem_addr0) : 32'h0;
      mem_rdata0 <= rdPipe0;
   end

   // One-cycle memory for the MEM_LAT=1 instance
   always @(posedge clock) begin
      mem_rdata1 <= mem_en1 ? lookup(mem_addr1) : 32'h0;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalChecks++;
      if (obs !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                                input logic dw, input logic [31:0] da, input logic [31:0] dd);
      ifReq0   = ir;
      ifAddr0  = ia;
      dmReq0   = dr;
      dmWe0    = dw;
      dmAddr0  = da;
      dmWdata0 = dd;
      #1;
   endtask

   task automatic nextCycle();
      @(posedge clock);
      #1;
   endtask

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int dmAt, ifAt, enCount, readyAt, nGrants;
      logic [5:0] grantIsIf;
      logic readySeen;

      reset = 1'b1;
      ifReq1 = 1'b0;
      ifAddr1 = 32'h0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (2) nextCycle();
      checkOutput("rst_mem_en", 32'(mem_en0), 32'd0);
      checkOutput("rst_busy", 32'(busy0), 32'd0);
      checkOutput("rst_if_ready", 32'(if_ready0), 32'd0);
      checkOutput("rst_dm_ready", 32'(dm_ready0), 32'd0);
      checkOutput("rst_mem_addr", mem_addr0, 32'h0);
      checkOutput("rst_if_rdata", if_rdata0, 32'h0);
      checkOutput("rst_busy1", 32'(busy1), 32'd0);
      reset = 1'b0;
      nextCycle();

      $display("[TB] T1 lone fetch");
      applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("t1_stall_c0", 32'(stall_if0), 32'd1);
      checkOutput("t1_busy_c0", 32'(busy0), 32'd0);
      for (int c = 1; c <= 5; c++) begin
         nextCycle();
         checkOutput($sformatf("t1_mem_en_c%0d", c), 32'(mem_en0), 32'(c == 1));
         checkOutput($sformatf("t1_if_ready_c%0d", c), 32'(if_ready0), 32'(c == 4));
         checkOutput($sformatf("t1_stall_if_c%0d", c), 32'(stall_if0), 32'(c < 4));
         if (c == 1) begin
            checkOutput("t1_mem_addr", mem_addr0, 32'h40);
            checkOutput("t1_mem_we", 32'(mem_we0), 32'd0);
         end
         if (c == 4) begin
            checkOutput("t1_if_rdata", if_rdata0, 32'h8C020000);
            applyStimulus(1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
         end
      end
      checkOutput("t1_if_rdata_hold", if_rdata0, 32'h8C020000);
      checkOutput("t1_busy_after", 32'(busy0), 32'd0);

      $display("[TB] T2 simultaneous fetch and load");
      applyStimulus(1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0);
      dmAt = -1;
      ifAt = -1;
      for (int c = 1; c <= 12; c++) begin
         nextCycle();
         if (c == 1) checkOutput("t2_first_grant", mem_addr0, 32'h100);
         if (c == 1) checkOutput("t2_first_en", 32'(mem_en0), 32'd1);
         if (c == 5) checkOutput("t2_second_grant", mem_addr0, 32'h44);
         if (c == 5) checkOutput("t2_second_en", 32'(mem_en0), 32'd1);
         if (dm_ready0 && dmAt < 0) begin
            dmAt = c;
            checkOutput("t2_dm_rdata", dm_rdata0, 32'h0100FEFF);
            dmReq0 = 1'b0;
         end
         if (if_ready0 && ifAt < 0) begin
            ifAt = c;
            checkOutput("t2_if_rdata", if_rdata0, 32'h0044FFBB);
            ifReq0 = 1'b0;
         end
      end
      checkOutput("t2_dm_ready_cycle", 32'(dmAt), 32'd4);
      checkOutput("t2_if_ready_cycle", 32'(ifAt), 32'd8);

      $display("[TB] T4 store");
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF);
      checkOutput("t4_stall_mem_c0", 32'(stall_mem0), 32'd1);
      enCount = 0;
      readyAt = -1;
      for (int c = 1; c <= 6; c++) begin
         nextCycle();
         if (mem_en0) begin
            enCount++;
            checkOutput("t4_mem_we", 32'(mem_we0), 32'd1);
            checkOutput("t4_mem_addr", mem_addr0, 32'h20);
            checkOutput("t4_mem_wdata", mem_wdata0, 32'hDEADBEEF);
         end
         if (c == 2) checkOutput("t4_mem_we_c2", 32'(mem_we0), 32'd0);
         if (dm_ready0 && readyAt < 0) begin
            readyAt = c;
            checkOutput("t4_dm_rdata_kept", dm_rdata0, 32'h0100FEFF);
            dmReq0 = 1'b0;
         end
      end
      checkOutput("t4_en_cycles", 32'(enCount), 32'd1);
      checkOutput("t4_ready_cycle", 32'(readyAt), 32'd4);

      $display("[TB] T3 fetch starvation guard");
      applyStimulus(1'b1, 32'h300, 1'b1, 1'b0, 32'h200, 32'h0);
      nGrants = 0;
      grantIsIf = '0;
      for (int c = 1; c <= 80; c++) begin
         if (nGrants >= 6) break;
         @(posedge clock);
         #1;
         ifReq0 = ~dm_ready0;
         #1;
         if (mem_en0) begin
            grantIsIf[nGrants] = (mem_addr0 == 32'h300);
            nGrants++;
         end
      end
      checkOutput("t3_grant_count", 32'(nGrants), 32'd6);
      for (int g = 0; g < 6; g++)
         checkOutput($sformatf("t3_grant%0d_is_if", g), 32'(grantIsIf[g]), 32'(g == 4));
      ifReq0 = 1'b0;
      dmReq0 = 1'b0;
      repeat (8) nextCycle();
      checkOutput("t3_busy_after", 32'(busy0), 32'd0);

      $display("[TB] T5 reset during WAIT");
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h60, 32'h0);
      nextCycle();
      checkOutput("t5_issue", 32'(mem_en0), 32'd1);
      nextCycle();
      checkOutput("t5_wait_busy", 32'(busy0), 32'd1);
      reset = 1'b1;
      dmReq0 = 1'b0;
      #1;
      nextCycle();
      checkOutput("t5_busy", 32'(busy0), 32'd0);
      checkOutput("t5_mem_en", 32'(mem_en0), 32'd0);
      checkOutput("t5_mem_we", 32'(mem_we0), 32'd0);
      checkOutput("t5_dm_ready", 32'(dm_ready0), 32'd0);
      checkOutput("t5_if_ready", 32'(if_ready0), 32'd0);
      checkOutput("t5_dm_rdata", dm_rdata0, 32'h0);
      checkOutput("t5_if_rdata", if_rdata0, 32'h0);
      checkOutput("t5_mem_addr", mem_addr0, 32'h0);
      checkOutput("t5_mem_wdata", mem_wdata0, 32'h0);
      checkOutput("t5_stall_mem", 32'(stall_mem0), 32'd0);
      reset = 1'b0;
      readySeen = 1'b0;
      repeat (4) begin
         nextCycle();
         readySeen = readySeen | dm_ready0 | if_ready0 | mem_en0;
      end
      checkOutput("t5_no_late_ready", 32'(readySeen), 32'd0);

      $display("[TB] T6 MEM_LAT=1 held fetch");
      ifReq1 = 1'b1;
      ifAddr1 = 32'h80;
      #1;
      for (int c = 1; c <= 5; c++) begin
         nextCycle();
         checkOutput($sformatf("t6_mem_en_c%0d", c), 32'(mem_en1), 32'(c == 1 || c == 5));
         checkOutput($sformatf("t6_if_ready_c%0d", c), 32'(if_ready1), 32'(c == 3));
         checkOutput($sformatf("t6_busy_c%0d", c), 32'(busy1), 32'(c == 1 || c == 2 || c == 5));
         if (c == 3) begin
            checkOutput("t6_if_rdata", if_rdata1, 32'h0080FF7F);
            checkOutput("t6_stall_if", 32'(stall_if1), 32'd0);
         end
      end
      ifReq1 = 1'b0;
      repeat (4) nextCycle();

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
